// File: rtl/nap_axi_resp_pkg.sv
// Shared types and constants for the NAP AXI4 memory responder.
package nap_axi_resp_pkg;

    localparam int unsigned NAP_DATA_WIDTH = 256;
    localparam int unsigned NAP_ADDR_WIDTH = 42;
    localparam int unsigned NAP_ID_WIDTH   = 8;
    localparam int unsigned BYTES_PER_BEAT = NAP_DATA_WIDTH / 8;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_BURST
    } rd_state_t;

    // WRAP is handled as INCR; FIXED and reserved encodings hold the address.
    function automatic logic burst_advances(input logic [1:0] burst);
        return (burst == AXI_BURST_INCR) || (burst == AXI_BURST_WRAP);
    endfunction

endpackage

// File: rtl/nap_axi_resp_ram.sv
// Simple dual-port RAM: byte-enable write port, registered read port, read-first.
module nap_axi_resp_ram
    import nap_axi_resp_pkg::*;
#(
    parameter int unsigned DEPTH      = 512,
    parameter int unsigned DATA_WIDTH = NAP_DATA_WIDTH
) (
    input  logic                       i_clk,
    input  logic                       we_i,
    input  logic [$clog2(DEPTH)-1:0]   waddr_i,
    input  logic [DATA_WIDTH-1:0]      wdata_i,
    input  logic [DATA_WIDTH/8-1:0]    wbe_i,
    input  logic                       re_i,
    input  logic [$clog2(DEPTH)-1:0]   raddr_i,
    output logic [DATA_WIDTH-1:0]      rdata_o
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Byte-masked write and registered read; same-address read sees the old word.
    always_ff @(posedge i_clk) begin
        if (we_i) begin
            for (int b = 0; b < int'(BYTES); b++) begin
                if (wbe_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/nap_axi_mem_responder.sv
// AXI4 memory responder behind a slave NAP: answers AR/AW/W from on-chip RAM.
// Optional build macro NAP_RESP_ADDR_CHECK_EN: out-of-range addresses get SLVERR,
// writes suppressed and reads return zero.
module nap_axi_mem_responder
    import nap_axi_resp_pkg::*;
#(
    parameter int unsigned MEM_DEPTH  = 512,
    parameter int unsigned DATA_WIDTH = NAP_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = NAP_ADDR_WIDTH,
    parameter int unsigned ID_WIDTH   = NAP_ID_WIDTH
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    nap_awvalid_i,
    output logic                    nap_awready_o,
    input  logic [ID_WIDTH-1:0]     nap_awid_i,
    input  logic [ADDR_WIDTH-1:0]   nap_awaddr_i,
    input  logic [7:0]              nap_awlen_i,
    input  logic [1:0]              nap_awburst_i,
    input  logic                    nap_wvalid_i,
    output logic                    nap_wready_o,
    input  logic [DATA_WIDTH-1:0]   nap_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] nap_wstrb_i,
    input  logic                    nap_wlast_i,
    output logic                    nap_bvalid_o,
    input  logic                    nap_bready_i,
    output logic [ID_WIDTH-1:0]     nap_bid_o,
    output logic [1:0]              nap_bresp_o,
    input  logic                    nap_arvalid_i,
    output logic                    nap_arready_o,
    input  logic [ID_WIDTH-1:0]     nap_arid_i,
    input  logic [ADDR_WIDTH-1:0]   nap_araddr_i,
    input  logic [7:0]              nap_arlen_i,
    input  logic [1:0]              nap_arburst_i,
    output logic                    nap_rvalid_o,
    input  logic                    nap_rready_i,
    output logic [ID_WIDTH-1:0]     nap_rid_o,
    output logic [DATA_WIDTH-1:0]   nap_rdata_o,
    output logic [1:0]              nap_rresp_o,
    output logic                    nap_rlast_o,
    output logic                    o_busy,
    output logic                    o_proto_err
);

    localparam int unsigned IDX_W   = $clog2(MEM_DEPTH);
    localparam int unsigned IDX_LSB = $clog2(DATA_WIDTH / 8);
    localparam int unsigned IDX_TOP = IDX_LSB + IDX_W;

    // Write side
    wr_state_t             wr_state_q, wr_state_d;
    logic                  awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [ID_WIDTH-1:0]   bid_q, bid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [IDX_W-1:0]      wr_idx_q, wr_idx_d;
    logic [7:0]            wr_len_q, wr_len_d, wr_cnt_q, wr_cnt_d;
    logic                  wr_adv_q, wr_adv_d, wr_err_q, wr_err_d;
    logic                  proto_err_q, proto_err_d, busy_q, busy_d, ram_we;
    // Read side
    rd_state_t             rd_state_q, rd_state_d;
    logic                  arready_q, arready_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [IDX_W-1:0]      rd_idx_q, rd_idx_d;
    logic [7:0]            rd_len_q, rd_len_d, iss_cnt_q, iss_cnt_d;
    logic                  iss_done_q, iss_done_d, rd_adv_q, rd_adv_d, rd_err_q, rd_err_d;
    logic                  pend_q, pend_d, pend_last_q, pend_last_d;
    logic                  rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d, skid_data_q, skid_data_d;
    logic                  skid_v_q, skid_v_d, skid_last_q, skid_last_d;
    logic                  pop, issue;
    logic [1:0]            occ;
    logic [DATA_WIDTH-1:0] ram_rdata, arr_data;
    logic                  aw_range_err, ar_range_err;
    logic                  unused_low_bits;

    assign unused_low_bits = ^{nap_awaddr_i[IDX_LSB-1:0], nap_araddr_i[IDX_LSB-1:0]};

`ifdef NAP_RESP_ADDR_CHECK_EN
    assign aw_range_err = |nap_awaddr_i[ADDR_WIDTH-1:IDX_TOP];
    assign ar_range_err = |nap_araddr_i[ADDR_WIDTH-1:IDX_TOP];
`else
    logic unused_high_bits;
    assign unused_high_bits = ^{nap_awaddr_i[ADDR_WIDTH-1:IDX_TOP], nap_araddr_i[ADDR_WIDTH-1:IDX_TOP]};
    assign aw_range_err = 1'b0;
    assign ar_range_err = 1'b0;
`endif

    nap_axi_resp_ram #(.DEPTH(MEM_DEPTH), .DATA_WIDTH(DATA_WIDTH)) u_ram (
        .i_clk   (i_clk),
        .we_i    (ram_we),
        .waddr_i (wr_idx_q),
        .wdata_i (nap_wdata_i),
        .wbe_i   (nap_wstrb_i),
        .re_i    (issue),
        .raddr_i (rd_idx_q),
        .rdata_o (ram_rdata)
    );

    // Write FSM: AW latch, counted W beats into RAM, then hold B until accepted.
    always_comb begin
        wr_state_d  = wr_state_q;
        bid_d       = bid_q;
        bresp_d     = bresp_q;
        wr_idx_d    = wr_idx_q;
        wr_len_d    = wr_len_q;
        wr_cnt_d    = wr_cnt_q;
        wr_adv_d    = wr_adv_q;
        wr_err_d    = wr_err_q;
        proto_err_d = proto_err_q;
        ram_we      = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                if (nap_awvalid_i && awready_q) begin
                    wr_state_d = W_DATA;
                    bid_d      = nap_awid_i;
                    wr_idx_d   = nap_awaddr_i[IDX_LSB +: IDX_W];
                    wr_len_d   = nap_awlen_i;
                    wr_cnt_d   = 8'd0;
                    wr_adv_d   = burst_advances(nap_awburst_i);
                    wr_err_d   = aw_range_err;
                    bresp_d    = aw_range_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                end
            end
            W_DATA: begin
                if (nap_wvalid_i && wready_q) begin
                    ram_we   = !wr_err_q;
                    wr_cnt_d = wr_cnt_q + 8'd1;
                    if (nap_wlast_i != (wr_cnt_q == wr_len_q)) proto_err_d = 1'b1;
                    if (wr_adv_q) wr_idx_d = wr_idx_q + IDX_W'(1);
                    if (wr_cnt_q == wr_len_q) wr_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (nap_bready_i && bvalid_q) wr_state_d = W_IDLE;
            end
            default: wr_state_d = W_IDLE;
        endcase
        awready_d = (wr_state_d == W_IDLE);
        wready_d  = (wr_state_d == W_DATA);
        bvalid_d  = (wr_state_d == W_RESP);
    end

    // Read FSM: issue RAM reads while the 2-deep output stage (plus in-flight read) has room.
    always_comb begin
        pop      = rvalid_q && nap_rready_i;
        occ      = 2'(rvalid_q) + 2'(skid_v_q) + 2'(pend_q);
        issue    = (rd_state_q == R_BURST) && !iss_done_q && ((occ - 2'(pop)) < 2'd2);
        arr_data = rd_err_q ? '0 : ram_rdata;

        rd_state_d  = rd_state_q;
        rid_d       = rid_q;
        rresp_d     = rresp_q;
        rd_idx_d    = rd_idx_q;
        rd_len_d    = rd_len_q;
        iss_cnt_d   = iss_cnt_q;
        iss_done_d  = iss_done_q;
        rd_adv_d    = rd_adv_q;
        rd_err_d    = rd_err_q;
        pend_d      = issue;
        pend_last_d = issue && (iss_cnt_q == rd_len_q);
        rvalid_d    = rvalid_q;
        rdata_d     = rdata_q;
        rlast_d     = rlast_q;
        skid_v_d    = skid_v_q;
        skid_data_d = skid_data_q;
        skid_last_d = skid_last_q;

        case (rd_state_q)
            R_IDLE: begin
                if (nap_arvalid_i && arready_q) begin
                    rd_state_d = R_BURST;
                    rid_d      = nap_arid_i;
                    rd_idx_d   = nap_araddr_i[IDX_LSB +: IDX_W];
                    rd_len_d   = nap_arlen_i;
                    iss_cnt_d  = 8'd0;
                    iss_done_d = 1'b0;
                    rd_adv_d   = burst_advances(nap_arburst_i);
                    rd_err_d   = ar_range_err;
                    rresp_d    = ar_range_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                end
            end
            R_BURST: begin
                if (issue) begin
                    iss_cnt_d = iss_cnt_q + 8'd1;
                    if (rd_adv_q) rd_idx_d = rd_idx_q + IDX_W'(1);
                    if (iss_cnt_q == rd_len_q) iss_done_d = 1'b1;
                end
                if (pop && rlast_q) rd_state_d = R_IDLE;
            end
            default: rd_state_d = R_IDLE;
        endcase

        if (pend_q) begin
            if (!rvalid_q || pop) begin
                rvalid_d = 1'b1;
                if (skid_v_q) begin
                    rdata_d     = skid_data_q;
                    rlast_d     = skid_last_q;
                    skid_data_d = arr_data;
                    skid_last_d = pend_last_q;
                end else begin
                    rdata_d = arr_data;
                    rlast_d = pend_last_q;
                end
            end else begin
                skid_v_d    = 1'b1;
                skid_data_d = arr_data;
                skid_last_d = pend_last_q;
            end
        end else if (pop) begin
            if (skid_v_q) begin
                rdata_d  = skid_data_q;
                rlast_d  = skid_last_q;
                skid_v_d = 1'b0;
            end else begin
                rvalid_d = 1'b0;
                rlast_d  = 1'b0;
            end
        end
        arready_d = (rd_state_d == R_IDLE);
    end

    assign busy_d = (wr_state_d != W_IDLE) || (rd_state_d != R_IDLE);

    // State and datapath registers; RAM contents are not affected by reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_state_q  <= W_IDLE;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            bid_q       <= '0;
            bresp_q     <= AXI_RESP_OKAY;
            wr_idx_q    <= '0;
            wr_len_q    <= 8'd0;
            wr_cnt_q    <= 8'd0;
            wr_adv_q    <= 1'b0;
            wr_err_q    <= 1'b0;
            proto_err_q <= 1'b0;
            busy_q      <= 1'b0;
            rd_state_q  <= R_IDLE;
            arready_q   <= 1'b0;
            rid_q       <= '0;
            rresp_q     <= AXI_RESP_OKAY;
            rd_idx_q    <= '0;
            rd_len_q    <= 8'd0;
            iss_cnt_q   <= 8'd0;
            iss_done_q  <= 1'b0;
            rd_adv_q    <= 1'b0;
            rd_err_q    <= 1'b0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            rlast_q     <= 1'b0;
            skid_v_q    <= 1'b0;
            skid_data_q <= '0;
            skid_last_q <= 1'b0;
        end else begin
            wr_state_q  <= wr_state_d;
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            bvalid_q    <= bvalid_d;
            bid_q       <= bid_d;
            bresp_q     <= bresp_d;
            wr_idx_q    <= wr_idx_d;
            wr_len_q    <= wr_len_d;
            wr_cnt_q    <= wr_cnt_d;
            wr_adv_q    <= wr_adv_d;
            wr_err_q    <= wr_err_d;
            proto_err_q <= proto_err_d;
            busy_q      <= busy_d;
            rd_state_q  <= rd_state_d;
            arready_q   <= arready_d;
            rid_q       <= rid_d;
            rresp_q     <= rresp_d;
            rd_idx_q    <= rd_idx_d;
            rd_len_q    <= rd_len_d;
            iss_cnt_q   <= iss_cnt_d;
            iss_done_q  <= iss_done_d;
            rd_adv_q    <= rd_adv_d;
            rd_err_q    <= rd_err_d;
            pend_q      <= pend_d;
            pend_last_q <= pend_last_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            rlast_q     <= rlast_d;
            skid_v_q    <= skid_v_d;
            skid_data_q <= skid_data_d;
            skid_last_q <= skid_last_d;
        end
    end

    assign nap_awready_o = awready_q;
    assign nap_wready_o  = wready_q;
    assign nap_bvalid_o  = bvalid_q;
    assign nap_bid_o     = bid_q;
    assign nap_bresp_o   = bresp_q;
    assign nap_arready_o = arready_q;
    assign nap_rvalid_o  = rvalid_q;
    assign nap_rid_o     = rid_q;
    assign nap_rdata_o   = rdata_q;
    assign nap_rresp_o   = rresp_q;
    assign nap_rlast_o   = rlast_q;
    assign o_busy        = busy_q;
    assign o_proto_err   = proto_err_q;

endmodule

// File: tb/tb_nap_axi_mem_responder.sv
// Directed bench for nap_axi_mem_responder (honours NAP_RESP_ADDR_CHECK_EN).
module tb_nap_axi_mem_responder;

    localparam int unsigned DW = 256;
    localparam int unsigned AW = 42;
    localparam int unsigned IW = 8;

    logic i_clk = 1'b0;
    logic i_reset = 1'b1;
    always #5 i_clk = ~i_clk;

    logic          awvalid = 0, awready, wvalid = 0, wready, wlast = 0, bvalid, bready = 0;
    logic [IW-1:0] awid = 0, bid, arid = 0, rid;
    logic [AW-1:0] awaddr = 0, araddr = 0;
    logic [7:0]    awlen = 0, arlen = 0;
    logic [1:0]    awburst = 0, arburst = 0, bresp, rresp;
    logic [DW-1:0] wdata = 0, rdata;
    logic [31:0]   wstrb = 0;
    logic          arvalid = 0, arready, rvalid, rready = 0, rlast, busy, proto_err;

    nap_axi_mem_responder dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .nap_awvalid_i(awvalid), .nap_awready_o(awready), .nap_awid_i(awid),
        .nap_awaddr_i(awaddr), .nap_awlen_i(awlen), .nap_awburst_i(awburst),
        .nap_wvalid_i(wvalid), .nap_wready_o(wready), .nap_wdata_i(wdata),
        .nap_wstrb_i(wstrb), .nap_wlast_i(wlast),
        .nap_bvalid_o(bvalid), .nap_bready_i(bready), .nap_bid_o(bid), .nap_bresp_o(bresp),
        .nap_arvalid_i(arvalid), .nap_arready_o(arready), .nap_arid_i(arid),
        .nap_araddr_i(araddr), .nap_arlen_i(arlen), .nap_arburst_i(arburst),
        .nap_rvalid_o(rvalid), .nap_rready_i(rready), .nap_rid_o(rid), .nap_rdata_o(rdata),
        .nap_rresp_o(rresp), .nap_rlast_o(rlast),
        .o_busy(busy), .o_proto_err(proto_err)
    );

    int tests = 0;
    int fails = 0;
    logic [DW-1:0] wtab [8];
    logic [31:0]   stab [8];
    logic [DW-1:0] rtab [8];
    logic          ltab [8];
    logic [1:0]    rresp_tab [8];
    logic [IW-1:0] rid_tab [8];
    int first_cyc, last_cyc;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic tmo(input string tag);
        tests++;
        fails++;
        $error("FAIL %s: bound expired waiting for DUT", tag);
    endtask

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [DW-1:0] t1_beat(input int k);
        return {32{8'(k + 1)}};
    endfunction

    function automatic logic [DW-1:0] t3_beat(input int k);
        return {8{32'hA5A5_0000 + 32'(k)}};
    endfunction

    task automatic axi_write(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input int wlast_at, input logic [1:0] exp_resp);
        int n;
        awvalid = 1; awid = id; awaddr = addr; awlen = len; awburst = burst;
        n = 0;
        while (awready !== 1'b1 && n < 20) begin tick; n++; end
        if (awready !== 1'b1) tmo("aw_wait");
        tick;
        awvalid = 0;
        for (int b = 0; b <= int'(len); b++) begin
            wvalid = 1; wdata = wtab[b]; wstrb = stab[b]; wlast = (b == wlast_at);
            n = 0;
            while (wready !== 1'b1 && n < 20) begin tick; n++; end
            if (wready !== 1'b1) tmo("w_wait");
            chk("bvalid_during_w", DW'(bvalid), DW'(1'b0));
            tick;
        end
        wvalid = 0; wlast = 0; bready = 1;
        n = 0;
        while (bvalid !== 1'b1 && n < 20) begin tick; n++; end
        if (bvalid !== 1'b1) tmo("b_wait");
        chk("bid", DW'(bid), DW'(id));
        chk("bresp", DW'(bresp), DW'(exp_resp));
        tick;
        bready = 0;
    endtask

    task automatic axi_read(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                            input bit toggle);
        int n, cyc, nb;
        logic stalled, sl;
        logic [DW-1:0] sd;
        arvalid = 1; arid = id; araddr = addr; arlen = len; arburst = 2'b01;
        n = 0;
        while (arready !== 1'b1 && n < 20) begin tick; n++; end
        if (arready !== 1'b1) tmo("ar_wait");
        tick;
        arvalid = 0;
        cyc = 0; nb = 0; stalled = 0; sd = '0; sl = 0; first_cyc = -1; last_cyc = -1;
        while (nb <= int'(len) && cyc < 200) begin
            rready = toggle ? (cyc % 2 == 1) : 1'b1;
            if (stalled) begin
                chk("r_stall_valid", DW'(rvalid), DW'(1'b1));
                chk("r_stall_data", rdata, sd);
                chk("r_stall_last", DW'(rlast), DW'(sl));
            end
            if (rvalid === 1'b1 && first_cyc < 0) first_cyc = cyc;
            stalled = (rvalid === 1'b1) && !rready;
            sd = rdata; sl = rlast;
            if (rvalid === 1'b1 && rready) begin
                rtab[nb] = rdata; ltab[nb] = rlast; rresp_tab[nb] = rresp; rid_tab[nb] = rid;
                last_cyc = cyc;
                nb++;
            end
            tick;
            cyc++;
        end
        rready = 0;
        if (nb <= int'(len)) tmo("r_beats");
    endtask

    initial begin
        int n, nb;
        // Reset
        tick; tick; tick;
        chk("rst_arready", DW'(arready), DW'(1'b0));
        chk("rst_awready", DW'(awready), DW'(1'b0));
        chk("rst_rvalid", DW'(rvalid), DW'(1'b0));
        chk("rst_bvalid", DW'(bvalid), DW'(1'b0));
        chk("rst_busy", DW'(busy), DW'(1'b0));
        chk("rst_proto", DW'(proto_err), DW'(1'b0));
        i_reset = 0;
        tick;
        chk("rel_arready", DW'(arready), DW'(1'b1));
        chk("rel_awready", DW'(awready), DW'(1'b1));

        // 1: INCR write of 4 beats, read back
        for (int k = 0; k < 4; k++) begin wtab[k] = t1_beat(k); stab[k] = '1; end
        axi_write(8'h12, 42'h1000, 8'd3, 2'b01, 3, 2'b00);
        axi_read(8'h12, 42'h1000, 8'd3, 1'b0);
        for (int k = 0; k < 4; k++) begin
            chk("t1_rdata", rtab[k], t1_beat(k));
            chk("t1_rlast", DW'(ltab[k]), DW'(k == 3));
            chk("t1_rid", DW'(rid_tab[k]), DW'(8'h12));
            chk("t1_rresp", DW'(rresp_tab[k]), DW'(2'b00));
        end
        chk("t1_first_rvalid", DW'(first_cyc), DW'(2));

        // 2: byte strobes
        wtab[0] = '1; stab[0] = '1;
        axi_write(8'h01, 42'h0, 8'd0, 2'b01, 0, 2'b00);
        wtab[0] = {{28{8'hAB}}, 32'h1122_3344}; stab[0] = 32'h0000_000F;
        axi_write(8'h02, 42'h0, 8'd0, 2'b01, 0, 2'b00);
        axi_read(8'h02, 42'h0, 8'd0, 1'b0);
        chk("t2_strobe", rtab[0], {{28{8'hFF}}, 32'h1122_3344});

        // 3: 8-beat read with rready toggling, then held high
        for (int k = 0; k < 8; k++) begin wtab[k] = t3_beat(k); stab[k] = '1; end
        axi_write(8'h33, 42'h2000, 8'd7, 2'b01, 7, 2'b00);
        axi_read(8'h33, 42'h2000, 8'd7, 1'b1);
        for (int k = 0; k < 8; k++) chk("t3_toggle_data", rtab[k], t3_beat(k));
        chk("t3_toggle_rlast", DW'(ltab[7]), DW'(1'b1));
        chk("t3_after_rvalid", DW'(rvalid), DW'(1'b0));
        chk("t3_after_arready", DW'(arready), DW'(1'b1));
        axi_read(8'h34, 42'h2000, 8'd7, 1'b0);
        for (int k = 0; k < 8; k++) chk("t3_full_data", rtab[k], t3_beat(k));
        chk("t3_full_first", DW'(first_cyc), DW'(2));
        chk("t3_full_span", DW'(last_cyc - first_cyc), DW'(7));
        chk("t3_rid", DW'(rid_tab[7]), DW'(8'h34));

        // 4: FIXED burst keeps the last beat; misplaced WLAST flags a protocol error
        for (int k = 0; k < 4; k++) begin wtab[k] = {8{32'hC0DE_0000 + 32'(k)}}; stab[k] = '1; end
        axi_write(8'h44, 42'h40, 8'd3, 2'b00, 3, 2'b00);
        axi_read(8'h44, 42'h40, 8'd0, 1'b0);
        chk("t4_fixed", rtab[0], {8{32'hC0DE_0003}});
        chk("t4_fixed_rlast", DW'(ltab[0]), DW'(1'b1));
        chk("t4_proto_before", DW'(proto_err), DW'(1'b0));
        axi_write(8'h45, 42'h80, 8'd3, 2'b01, 1, 2'b00);
        chk("t4_proto_after", DW'(proto_err), DW'(1'b1));

        // 5: reset during beat 3 of an 8-beat read
        arvalid = 1; arid = 8'h55; araddr = 42'h2000; arlen = 8'd7; arburst = 2'b01;
        n = 0;
        while (arready !== 1'b1 && n < 20) begin tick; n++; end
        if (arready !== 1'b1) tmo("t5_ar_wait");
        tick;
        arvalid = 0; rready = 1;
        nb = 0; n = 0;
        while (nb < 2 && n < 50) begin
            if (rvalid === 1'b1) nb++;
            tick;
            n++;
        end
        if (nb < 2) tmo("t5_beats");
        chk("t5_beat3_data", rdata, t3_beat(2));
        i_reset = 1;
        tick;
        chk("t5_rvalid_rst", DW'(rvalid), DW'(1'b0));
        chk("t5_arready_rst", DW'(arready), DW'(1'b0));
        chk("t5_proto_rst", DW'(proto_err), DW'(1'b0));
        i_reset = 0; rready = 0;
        tick;
        chk("t5_arready_rel", DW'(arready), DW'(1'b1));
        axi_read(8'h56, 42'h2000, 8'd7, 1'b0);
        for (int k = 0; k < 8; k++) chk("t5_reread", rtab[k], t3_beat(k));

        // 6: address above the RAM range
        axi_read(8'h66, 42'h4000_0000, 8'd0, 1'b0);
`ifdef NAP_RESP_ADDR_CHECK_EN
        chk("t6_rresp", DW'(rresp_tab[0]), DW'(2'b10));
        chk("t6_rdata", rtab[0], '0);
`else
        chk("t6_rresp", DW'(rresp_tab[0]), DW'(2'b00));
        chk("t6_rdata", rtab[0], {{28{8'hFF}}, 32'h1122_3344});
`endif
        chk("t6_rid", DW'(rid_tab[0]), DW'(8'h66));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
